// File: rtl/branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with 2-bit saturating
// counters, trained by EX-stage resolutions, with misprediction detection
// and saturating 32-bit statistics.
//
// Handshake: upd_valid is a one-cycle qualifier on the upd_* bundle. There
// is no ready. The table accepts every resolution on the clock edge where
// upd_valid = 1, and each resolved branch is presented exactly once.
module branch_predictor #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4,
  parameter int TAG_W   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] fetch_pc,
  output logic        pred_taken,
  output logic [63:0] pred_target,
  input  logic        upd_valid,
  input  logic [63:0] upd_pc,
  input  logic        upd_taken,
  input  logic [63:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [63:0] upd_pred_target,
  output logic        mispredict,
  output logic [63:0] redirect_pc,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  // Per-entry storage, kept in flops so that lookup is purely combinational.
  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [63:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [IDX_W-1:0] fetch_idx;
  logic [TAG_W-1:0] fetch_tag;
  logic [IDX_W-1:0] upd_idx;
  logic [TAG_W-1:0] upd_tag;
  logic             fetch_hit;
  logic             upd_hit;

  // Fetch PC bits that take no part in index or tag selection.
  logic unused_fetch_bits;
  assign unused_fetch_bits = ^{fetch_pc[63:IDX_W+TAG_W+2], fetch_pc[1:0]};

  assign fetch_idx = fetch_pc[IDX_W+1:2];
  assign fetch_tag = fetch_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign upd_idx   = upd_pc[IDX_W+1:2];
  assign upd_tag   = upd_pc[IDX_W+TAG_W+1:IDX_W+2];

  // Lookup reads the current (pre-update) table contents.
  always_comb begin
    fetch_hit   = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
    upd_hit     = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    pred_taken  = fetch_hit && ctr_q[fetch_idx][1];
    pred_target = pred_taken ? target_q[fetch_idx] : 64'd0;
  end

  // Misprediction check against the prediction carried down the pipeline.
  always_comb begin
    mispredict  = upd_valid &&
                  ((upd_pred_taken != upd_taken) ||
                   (upd_taken && (upd_pred_target != upd_target)));
    redirect_pc = 64'd0;
    if (mispredict) begin
      redirect_pc = upd_taken ? upd_target : (upd_pc + 64'd4);
    end
  end

  // Table training: counter hysteresis on hits, allocate only on a taken miss.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= 64'd0;
        ctr_q[i]    <= 2'b01;
      end
    end else if (upd_valid) begin
      if (upd_hit) begin
        if (upd_taken) begin
          ctr_q[upd_idx]    <= (ctr_q[upd_idx] == 2'b11) ? 2'b11 : ctr_q[upd_idx] + 2'b01;
          target_q[upd_idx] <= upd_target;
        end else begin
          ctr_q[upd_idx]    <= (ctr_q[upd_idx] == 2'b00) ? 2'b00 : ctr_q[upd_idx] - 2'b01;
        end
      end else if (upd_taken) begin
        valid_q[upd_idx]  <= 1'b1;
        tag_q[upd_idx]    <= upd_tag;
        target_q[upd_idx] <= upd_target;
        ctr_q[upd_idx]    <= 2'b10;
      end
    end
  end

  // Statistics counters, saturating at all-ones.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      branch_count     <= 32'd0;
      mispredict_count <= 32'd0;
    end else begin
      if (upd_valid && (branch_count != 32'hFFFF_FFFF)) begin
        branch_count <= branch_count + 32'd1;
      end
      if (mispredict && (mispredict_count != 32'hFFFF_FFFF)) begin
        mispredict_count <= mispredict_count + 32'd1;
      end
    end
  end

endmodule
